mem_bus_ctrl: RTL and testbench

- Sequences core data-memory requests onto the shared bidirectional data-memory bus pads.
- Sits between the core's memory port and the pad ring. Drives the address pads, the write-enable pad, and the bidirectional pad output-enable.
- Manages bus turnaround, read-latency wait and read-data capture, and gives the core a valid/ready request channel plus a one-cycle response pulse.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_bus_delay_cnt.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the data-memory bus controller.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      TURN    = 2'd2,
      RD_WAIT = 2'd3
   } state_t;

   localparam int ADDR_W_DFLT = 8;
   localparam int DATA_W_DFLT = 16;
   localparam int CNT_W       = 4;
   localparam int PERF_W      = 16;

   // Saturating increment for the optional performance counters
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_bus_delay_cnt.sv
// Loadable down-counter with zero flag; times both bus turnaround and read latency.
module mem_bus_delay_cnt
   import mem_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences core memory requests onto the shared bidirectional data bus pads.
// Optional MEMBUS_PERF_EN adds saturating read/write/turnaround event counters.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DFLT,
   parameter int DATA_W   = DATA_W_DFLT,
   parameter int READ_LAT = 2,
   parameter int TURN_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] pad_addr,
   output logic              pad_we,
   output logic              pad_oe,
   output logic [DATA_W-1:0] pad_dout,
   input  logic [DATA_W-1:0] pad_din
`ifdef MEMBUS_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_rd_cnt,
   output logic [PERF_W-1:0] perf_wr_cnt,
   output logic [PERF_W-1:0] perf_turn_cnt
`endif
);

   localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] TURN_LOAD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
   localparam bit               HAS_TURN  = (TURN_CYC > 0);

   state_t           state_reg;
   logic             wr_last_reg;
   logic             accept;
   logic             go_turn;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;

   // req_ready is low for the first cycle after reset, so it gates acceptance rather than state
   assign accept  = req_valid && req_ready;
   assign go_turn = !req_we && wr_last_reg && HAS_TURN;

   always_comb begin
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      cnt_load_val = RD_LOAD;
      case (state_reg)
         IDLE: begin
            if (accept && !req_we) begin
               cnt_load     = 1'b1;
               cnt_load_val = go_turn ? TURN_LOAD : RD_LOAD;
            end
         end
         TURN: begin
            if (cnt_zero) cnt_load = 1'b1;
            else          cnt_dec  = 1'b1;
         end
         RD_WAIT: cnt_dec = 1'b1;
         default: ;
      endcase
   end

   mem_bus_delay_cnt u_delay_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         wr_last_reg <= 1'b0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         pad_addr    <= '0;
         pad_we      <= 1'b0;
         pad_oe      <= 1'b0;
         pad_dout    <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  pad_addr  <= req_addr;
                  if (req_we) begin
                     pad_dout  <= req_wdata;
                     pad_we    <= 1'b1;
                     pad_oe    <= 1'b1;
                     state_reg <= WR;
                  end else if (go_turn) begin
                     state_reg <= TURN;
                  end else begin
                     state_reg <= RD_WAIT;
                  end
               end
            end
            WR: begin
               pad_we      <= 1'b0;
               pad_oe      <= 1'b0;
               wr_last_reg <= 1'b1;
               req_ready   <= 1'b1;
               state_reg   <= IDLE;
            end
            TURN: begin
               if (cnt_zero) begin
                  wr_last_reg <= 1'b0;
                  state_reg   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // Data is valid on pad_din on the edge where the latency count has run out
               if (cnt_zero) begin
                  rsp_rdata   <= pad_din;
                  rsp_valid   <= 1'b1;
                  req_ready   <= 1'b1;
                  wr_last_reg <= 1'b0;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef MEMBUS_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_rd_cnt   <= '0;
         perf_wr_cnt   <= '0;
         perf_turn_cnt <= '0;
      end else begin
         if (rsp_valid)          perf_rd_cnt   <= sat_inc(perf_rd_cnt);
         if (state_reg == WR)    perf_wr_cnt   <= sat_inc(perf_wr_cnt);
         if (state_reg == TURN)  perf_turn_cnt <= sat_inc(perf_turn_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: vector table, corner sequences and random traffic
// against a transaction-schedule model. Exercises perf counters when MEMBUS_PERF_EN is set.
module tb_mem_bus_ctrl;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 16;
   localparam int READ_LAT = 2;
   localparam int TURN_CYC = 1;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] pad_addr;
   logic              pad_we;
   logic              pad_oe;
   logic [DATA_W-1:0] pad_dout;
   logic [DATA_W-1:0] pad_din;
`ifdef MEMBUS_PERF_EN
   logic [15:0]       perf_rd_cnt;
   logic [15:0]       perf_wr_cnt;
   logic [15:0]       perf_turn_cnt;
`endif

   mem_bus_ctrl #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .READ_LAT (READ_LAT),
      .TURN_CYC (TURN_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .pad_addr  (pad_addr),
      .pad_we    (pad_we),
      .pad_oe    (pad_oe),
      .pad_dout  (pad_dout),
      .pad_din   (pad_din)
`ifdef MEMBUS_PERF_EN
      ,
      .perf_rd_cnt   (perf_rd_cnt),
      .perf_wr_cnt   (perf_wr_cnt),
      .perf_turn_cnt (perf_turn_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: each transaction is a schedule of the cycles in which its effects appear
   int          ready_at;
   int          we_at;
   int          rsp_at;
   int          turn_lo;
   int          turn_hi;
   bit          m_wr_last;
   bit          acc_flag;
   logic [7:0]  m_addr;
   logic [15:0] m_dout;
   logic [15:0] m_rdata;
   int          m_rd;
   int          m_wr;
   int          m_turn;

   // pad_din carries a distinct value every cycle so the capture edge is observable
   function automatic logic [15:0] din_of(input int c);
      return 16'((c * 40503) ^ 23130);
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      ready_at  = 1 << 30;
      we_at     = -1;
      rsp_at    = -1;
      turn_lo   = -1;
      turn_hi   = -2;
      m_wr_last = 1'b0;
      m_addr    = '0;
      m_dout    = '0;
      m_rdata   = '0;
      m_rd      = 0;
      m_wr      = 0;
      m_turn    = 0;
   endtask

   task automatic model_check();
      int lat;
      acc_flag = 1'b0;
      if (cyc == rsp_at) m_rdata = din_of(cyc - 1);
      chk1("req_ready", req_ready, cyc >= ready_at);
      chk1("pad_we",    pad_we,    cyc == we_at);
      chk1("pad_oe",    pad_oe,    cyc == we_at);
      chk1("rsp_valid", rsp_valid, cyc == rsp_at);
      chkv("pad_addr",  32'(pad_addr),  32'(m_addr));
      chkv("pad_dout",  32'(pad_dout),  32'(m_dout));
      chkv("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
`ifdef MEMBUS_PERF_EN
      chkv("perf_rd",   32'(perf_rd_cnt),   32'(m_rd));
      chkv("perf_wr",   32'(perf_wr_cnt),   32'(m_wr));
      chkv("perf_turn", 32'(perf_turn_cnt), 32'(m_turn));
      if (cyc == rsp_at && m_rd < 65535) m_rd++;
      if (cyc == we_at && m_wr < 65535) m_wr++;
      if (cyc >= turn_lo && cyc <= turn_hi && m_turn < 65535) m_turn++;
`endif
      if (req_valid && cyc >= ready_at) begin
         acc_flag = 1'b1;
         m_addr   = req_addr;
         if (req_we) begin
            m_dout    = req_wdata;
            we_at     = cyc + 1;
            ready_at  = cyc + 2;
            m_wr_last = 1'b1;
         end else begin
            lat = READ_LAT + 1;
            if (m_wr_last && TURN_CYC > 0) begin
               lat     = lat + TURN_CYC;
               turn_lo = cyc + 1;
               turn_hi = cyc + TURN_CYC;
            end
            rsp_at    = cyc + lat;
            ready_at  = cyc + lat;
            m_wr_last = 1'b0;
         end
      end
   endtask

   task automatic run_cycle(input bit v, input bit we, input logic [7:0] addr,
                            input logic [15:0] wdata);
      @(posedge clk);
      #1;
      cyc++;
      req_valid = v;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      pad_din   = din_of(cyc);
      @(negedge clk);
      model_check();
   endtask

   task automatic idle_cycle();
      run_cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
   endtask

   task automatic issue(input bit we, input logic [7:0] addr, input logic [15:0] wdata,
                        output bit acc);
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 30) begin
         run_cycle(1'b1, we, addr, wdata);
         acc = acc_flag;
         n++;
      end
      chk1("issue_accept", acc, 1'b1);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      cyc++;
      rst       = 1'b1;
      req_valid = 1'b0;
      pad_din   = din_of(cyc);
      model_reset();
      #1;
      chk1("rst_async_pad_we",    pad_we,    1'b0);
      chk1("rst_async_pad_oe",    pad_oe,    1'b0);
      chk1("rst_async_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_async_req_ready", req_ready, 1'b0);
      chkv("rst_async_pad_addr",  32'(pad_addr), 32'h0);
      @(negedge clk);
      model_check();
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         pad_din = din_of(cyc);
         @(negedge clk);
         model_check();
      end
      @(posedge clk);
      #1;
      cyc++;
      rst      = 1'b0;
      pad_din  = din_of(cyc);
      ready_at = cyc + 1;
      @(negedge clk);
      model_check();
   endtask

   typedef struct {
      bit          we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      int          exp_off;   // cycles from accept to pad_we (write) or rsp_valid (read)
   } vec_t;

   vec_t tbl[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  a;
      int  n;
      int  k;
      int  pulses;
      int  last_acc;
      int  rsp_seen;
      bit  acc;
      bit  got;

      tbl[0] = '{1'b0, 8'h34, 16'h0000, 3};
      tbl[1] = '{1'b1, 8'h12, 16'hBEEF, 1};
      tbl[2] = '{1'b1, 8'h01, 16'h1111, 1};
      tbl[3] = '{1'b0, 8'h02, 16'h0000, 4};
      tbl[4] = '{1'b0, 8'h55, 16'h0000, 3};
      tbl[5] = '{1'b1, 8'hAA, 16'h5A5A, 1};
      tbl[6] = '{1'b0, 8'hAB, 16'h0000, 4};
      tbl[7] = '{1'b1, 8'hFF, 16'hFFFF, 1};

      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      pad_din   = '0;
      model_reset();

      do_reset(2);
      idle_cycle();
      idle_cycle();

      // Vector table: latency and data per transaction
      for (int i = 0; i < 8; i++) begin
         issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, acc);
         a   = cyc;
         n   = 0;
         got = 1'b0;
         while (!got && n < 20) begin
            idle_cycle();
            n++;
            got = tbl[i].we ? pad_we : rsp_valid;
         end
         chkv($sformatf("tbl%0d_offset", i), 32'(cyc - a), 32'(tbl[i].exp_off));
         if (tbl[i].we) begin
            chkv($sformatf("tbl%0d_addr", i), 32'(pad_addr), 32'(tbl[i].addr));
            chkv($sformatf("tbl%0d_dout", i), 32'(pad_dout), 32'(tbl[i].wdata));
         end else begin
            chkv($sformatf("tbl%0d_rdata", i), 32'(rsp_rdata),
                 32'(din_of(a + tbl[i].exp_off - 1)));
         end
      end

      // Four back-to-back writes with req_valid held high
      k        = 0;
      pulses   = 0;
      last_acc = -1;
      for (int j = 0; j < 9; j++) begin
         run_cycle(k < 4, 1'b1, 8'(8'h40 + k), 16'(16'hC000 + k));
         if (acc_flag) begin
            k++;
            last_acc = j;
         end
         if (pad_we) pulses++;
      end
      chkv("b2b_accepts",   32'(k),        32'd4);
      chkv("b2b_last_acc",  32'(last_acc), 32'd6);
      chkv("b2b_we_pulses", 32'(pulses),   32'd4);
      repeat (6) idle_cycle();

      // Reset in the middle of RD_WAIT
      issue(1'b0, 8'h66, 16'h0, acc);
      idle_cycle();
      do_reset(2);
      rsp_seen = 0;
      repeat (8) begin
         idle_cycle();
         if (rsp_valid) rsp_seen++;
      end
      chkv("rst_rdwait_no_rsp", 32'(rsp_seen), 32'd0);

      // Reset while the write pulse is on the pads
      issue(1'b1, 8'h77, 16'hA5A5, acc);
      do_reset(1);
      repeat (3) idle_cycle();

`ifdef MEMBUS_PERF_EN
      // Three writes, two reads, one write-to-read transition
      do_reset(1);
      issue(1'b1, 8'h10, 16'h0010, acc);
      issue(1'b1, 8'h11, 16'h0011, acc);
      issue(1'b1, 8'h12, 16'h0012, acc);
      issue(1'b0, 8'h13, 16'h0000, acc);
      issue(1'b0, 8'h14, 16'h0000, acc);
      repeat (8) idle_cycle();
      chkv("perf_wr_total",   32'(perf_wr_cnt),   32'd3);
      chkv("perf_rd_total",   32'(perf_rd_cnt),   32'd2);
      chkv("perf_turn_total", 32'(perf_turn_cnt), 32'd1);
`endif

      // Random traffic checked cycle by cycle against the model
      for (int r = 0; r < 600; r++) begin
         run_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   8'($urandom), 16'($urandom));
      end
      repeat (8) idle_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
